// File: rtl/uart_config_sequencer.sv
// Run-time UART line-settings sequencer: validate, quiesce TX/RX, load the
// config register, let the baud generator resync, then report.
module uart_config_sequencer #(
  parameter int TIMEOUT_CYCLES = 1048576,
  parameter int SETTLE_CYCLES  = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cfg_req,
  input  logic [3:0] cfg_baud_rate,
  input  logic [1:0] cfg_data_size,
  input  logic       cfg_parity_bit,
  input  logic       cfg_stop_bits,
  output logic       cfg_busy,
  output logic       cfg_done,
  output logic [1:0] cfg_err,
  input  logic       tx_busy,
  input  logic       rx_busy,
  output logic       hold,
  output logic       load_register,
  output logic [3:0] baud_rate,
  output logic [1:0] data_size,
  output logic       parity_bit,
  output logic       stop_bits,
  output logic       baud_resync
);
  localparam int DW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [DW-1:0] DRAIN_MAX   = DW'(TIMEOUT_CYCLES);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_DRAIN, S_LOAD, S_SETTLE, S_RESP
  } state_e;

  state_e          state_q, state_d;
  logic [DW-1:0]   drain_cnt_q, drain_cnt_d;
  logic [SW-1:0]   settle_cnt_q, settle_cnt_d;
  logic [1:0]      err_q, err_d;
  logic [3:0]      baud_q, baud_d;
  logic [1:0]      size_q, size_d;
  logic            par_q, par_d;
  logic            stop_q, stop_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            hold_q, hold_d;
  logic            load_q, load_d;

  always_comb begin
    state_d      = state_q;
    drain_cnt_d  = drain_cnt_q;
    settle_cnt_d = settle_cnt_q;
    err_d        = err_q;
    baud_d       = baud_q;
    size_d       = size_q;
    par_d        = par_q;
    stop_d       = stop_q;
    unique case (state_q)
      S_IDLE: if (cfg_req) begin
        baud_d  = cfg_baud_rate;
        size_d  = cfg_data_size;
        par_d   = cfg_parity_bit;
        stop_d  = cfg_stop_bits;
        err_d   = 2'b00;
        state_d = S_CHECK;
      end
      S_CHECK: begin
        drain_cnt_d = '0;
        if (baud_q > 4'd8) begin
          err_d   = 2'b01;
          state_d = S_RESP;
        end else begin
          state_d = S_DRAIN;
        end
      end
      // Link idle wins over timeout when both happen in the same cycle.
      S_DRAIN: begin
        if (!tx_busy && !rx_busy) begin
          state_d = S_LOAD;
        end else if (drain_cnt_q == DRAIN_MAX) begin
          err_d   = 2'b10;
          state_d = S_RESP;
        end else begin
          drain_cnt_d = drain_cnt_q + 1'b1;
        end
      end
      S_LOAD: begin
        settle_cnt_d = '0;
        state_d      = S_SETTLE;
      end
      S_SETTLE: begin
        if (settle_cnt_q == SETTLE_LAST) state_d = S_RESP;
        else settle_cnt_d = settle_cnt_q + 1'b1;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered copies of the next-state decode, so they line up with the state.
    busy_d = (state_d != S_IDLE);
    hold_d = (state_d == S_DRAIN) || (state_d == S_LOAD) || (state_d == S_SETTLE);
    load_d = (state_d == S_LOAD);
    done_d = (state_d == S_RESP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      drain_cnt_q  <= '0;
      settle_cnt_q <= '0;
      err_q        <= '0;
      baud_q       <= '0;
      size_q       <= '0;
      par_q        <= 1'b0;
      stop_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      hold_q       <= 1'b0;
      load_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      drain_cnt_q  <= drain_cnt_d;
      settle_cnt_q <= settle_cnt_d;
      err_q        <= err_d;
      baud_q       <= baud_d;
      size_q       <= size_d;
      par_q        <= par_d;
      stop_q       <= stop_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      hold_q       <= hold_d;
      load_q       <= load_d;
    end
  end

  assign cfg_busy      = busy_q;
  assign cfg_done      = done_q;
  assign cfg_err       = err_q;
  assign hold          = hold_q;
  assign load_register = load_q;
  assign baud_resync   = load_q;
  assign baud_rate     = baud_q;
  assign data_size     = size_q;
  assign parity_bit    = par_q;
  assign stop_bits     = stop_q;
endmodule

// File: tb/tb_uart_config_sequencer.sv
// Randomized scoreboard bench for uart_config_sequencer: a driver pushes the
// predicted response of each request, a monitor pops it on every cfg_done.
module tb_uart_config_sequencer;
  localparam int T = 8;
  localparam int S = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cfg_req = 1'b0;
  logic [3:0] cfg_baud_rate = '0;
  logic [1:0] cfg_data_size = '0;
  logic       cfg_parity_bit = 1'b0;
  logic       cfg_stop_bits = 1'b0;
  logic       tx_busy = 1'b0;
  logic       rx_busy = 1'b0;
  logic       cfg_busy, cfg_done, hold, load_register, parity_bit, stop_bits, baud_resync;
  logic [1:0] cfg_err, data_size;
  logic [3:0] baud_rate;

  uart_config_sequencer #(.TIMEOUT_CYCLES(T), .SETTLE_CYCLES(S)) dut (
    .clk(clk), .rst(rst), .cfg_req(cfg_req), .cfg_baud_rate(cfg_baud_rate),
    .cfg_data_size(cfg_data_size), .cfg_parity_bit(cfg_parity_bit),
    .cfg_stop_bits(cfg_stop_bits), .cfg_busy(cfg_busy), .cfg_done(cfg_done),
    .cfg_err(cfg_err), .tx_busy(tx_busy), .rx_busy(rx_busy), .hold(hold),
    .load_register(load_register), .baud_rate(baud_rate), .data_size(data_size),
    .parity_bit(parity_bit), .stop_bits(stop_bits), .baud_resync(baud_resync)
  );

  always #5 clk = ~clk;

  typedef struct {
    int err, done, load, baud, size, par, stop;
  } exp_t;

  exp_t exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Reference: the link goes idle in the first cycle after both busy windows
  // (tx busy cycles 1..t, rx busy 1..r), never earlier than cycle 2 (first DRAIN cycle).
  function automatic exp_t model(input int b, s, p, st, t, r);
    exp_t e;
    int k;
    e.baud = b; e.size = s; e.par = p; e.stop = st; e.load = 0;
    if (b > 8) begin
      e.err = 1; e.done = 2;
    end else begin
      k = ((t > r) ? t : r) + 1;
      if (k < 2) k = 2;
      if (k <= T + 2) begin
        e.err = 0; e.load = k + 1; e.done = k + 2 + S;
      end else begin
        e.err = 2; e.done = T + 3;
      end
    end
    return e;
  endfunction

  task automatic run_req(input int b, s, p, st, t, r, input bit ovl);
    exp_t e;
    e = model(b, s, p, st, t, r);
    exp_q.push_back(e);
    @(negedge clk);
    cfg_baud_rate = 4'(b); cfg_data_size = 2'(s);
    cfg_parity_bit = 1'(p); cfg_stop_bits = 1'(st);
    tx_busy = 1'b0; rx_busy = 1'b0; cfg_req = 1'b1;
    @(posedge clk);
    for (int rel = 1; rel <= e.done; rel++) begin
      @(negedge clk);
      tx_busy = (rel <= t);
      rx_busy = (rel <= r);
      cfg_req = ovl && (rel == 2 || rel == e.done - 1) && (rel < e.done);
      if (cfg_req) begin
        cfg_baud_rate = 4'($urandom_range(0, 15));
        cfg_data_size = 2'($urandom);
        cfg_parity_bit = 1'($urandom);
        cfg_stop_bits = 1'($urandom);
      end
    end
    cfg_req = 1'b0;
  endtask

  // Monitor: tracks the cycle index of the in-flight request and its observed behaviour.
  initial begin
    int rel, nload, load_rel, hold_n, lb, ls, lp, lst;
    bit prev_busy, resync_bad, wd_fired;
    exp_t e;
    rel = 0; nload = 0; load_rel = 0; hold_n = 0; lb = 0; ls = 0; lp = 0; lst = 0;
    prev_busy = 0; resync_bad = 0; wd_fired = 0;
    forever begin
      @(posedge clk);
      #1;
      if (cfg_busy && !prev_busy) begin
        rel = 1; nload = 0; hold_n = 0; load_rel = 0; resync_bad = 0; wd_fired = 0;
      end else if (cfg_busy) begin
        rel++;
      end
      prev_busy = cfg_busy;
      if (cfg_busy) begin
        if (hold) hold_n++;
        if (load_register) begin
          nload++; load_rel = rel;
          lb = baud_rate; ls = data_size; lp = parity_bit; lst = stop_bits;
        end
        if (load_register != baud_resync) resync_bad = 1;
        if (rel > 100 && !wd_fired) begin
          wd_fired = 1;
          chk("watchdog_no_done", rel, 100);
        end
      end
      if (cfg_done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("done_cycle", rel, e.done);
          chk("cfg_err", cfg_err, e.err);
          chk("load_count", nload, (e.err == 0) ? 1 : 0);
          chk("hold_cycles", hold_n, (e.err == 1) ? 0 : e.done - 2);
          chk("hold_in_resp", hold, 0);
          chk("resync_with_load", resync_bad, 0);
          if (e.err == 0) begin
            chk("load_cycle", load_rel, e.load);
            chk("load_baud", lb, e.baud);
            chk("load_size", ls, e.size);
            chk("load_parity", lp, e.par);
            chk("load_stop", lst, e.stop);
          end
          if (e.err != 1) chk("resp_baud", baud_rate, e.baud);
        end
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", cfg_busy, 0);
    chk("rst_done", cfg_done, 0);
    chk("rst_hold", hold, 0);
    chk("rst_load", load_register, 0);
    chk("rst_err", cfg_err, 0);
    chk("rst_baud", baud_rate, 0);
    @(negedge clk);
    rst = 1'b0;

    // Reset landing in SETTLE abandons the request immediately.
    @(negedge clk);
    cfg_baud_rate = 4'd5; cfg_data_size = 2'd2; cfg_parity_bit = 1'b1; cfg_stop_bits = 1'b1;
    cfg_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cfg_req = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    chk("pre_rst_hold", hold, 1);
    rst = 1'b1;
    #1;
    chk("async_rst_hold", hold, 0);
    chk("async_rst_load", load_register, 0);
    chk("async_rst_busy", cfg_busy, 0);
    chk("async_rst_done", cfg_done, 0);
    chk("async_rst_baud", baud_rate, 0);
    chk("async_rst_size", data_size, 0);
    @(negedge clk);
    rst = 1'b0;

    run_req(4, 3, 1, 1, 0, 0, 0);        // happy path
    run_req(6, 1, 0, 1, 10, 6, 0);       // drain wait
    run_req(9, 2, 1, 0, 0, 0, 0);        // invalid code
    run_req(2, 0, 0, 0, 0, 50, 0);       // rx stuck: timeout
    run_req(3, 1, 1, 0, 0, 0, 0);        // recovery after timeout
    run_req(8, 2, 0, 1, 0, T + 1, 0);    // idle exactly on last DRAIN cycle
    run_req(7, 3, 1, 1, 3, 5, 1);        // overlapping requests ignored
    for (int i = 0; i < 30; i++) begin
      int b, t, r;
      b = ($urandom_range(0, 3) == 0) ? $urandom_range(9, 15) : $urandom_range(0, 8);
      t = ($urandom_range(0, 4) == 0) ? 40 : $urandom_range(0, 11);
      r = $urandom_range(0, 11);
      run_req(b, $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 1),
              t, r, 1'($urandom));
    end
    repeat (5) @(posedge clk);
    #2;
    chk("pending_responses", exp_q.size(), 0);
    chk("idle_at_end", cfg_busy, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
